// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-M one-hot decoder for the register-enable and
// bus-select fabric. Four modes: DIRECT decode, HOLD, STEP (one-hot ring
// walk) and PULSE (one-hot strobe held PULSE_LEN cycles with a busy flag).
// Optional build macro DECODER_SEQ_STICKY_ERR_EN makes ERR sticky until a
// cycle with EN=0 and MODE=HOLD (or reset); by default ERR is a one-cycle flag.
module decoder_seq #(
   parameter int SEL_W     = 3,
   parameter int OUT_W     = 8,
   parameter int PULSE_LEN = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [SEL_W-1:0] in,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             step,
   output logic [OUT_W-1:0] out,
   output logic [SEL_W-1:0] idx,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_HOLD   = 2'b01,
      MODE_STEP   = 2'b10,
      MODE_PULSE  = 2'b11
   } mode_e;

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_e;

   // One extra bit so OUT_W == 2**SEL_W can be compared against IN.
   localparam logic [SEL_W:0]   OUT_W_EXT = (SEL_W+1)'(OUT_W);
   localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(OUT_W - 1);
   localparam logic [7:0]       CNT_LOAD  = 8'(PULSE_LEN - 1);
   localparam logic [OUT_W-1:0] ONE       = OUT_W'(1);

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
      return ONE << sel;
   endfunction

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [OUT_W-1:0] out_d;
   logic [SEL_W-1:0] idx_d;
   logic             busy_d, err_d;
   logic             in_ok;
   logic [SEL_W-1:0] idx_inc;
   mode_e            mode_s;

   assign mode_s  = mode_e'(mode);
   assign in_ok   = {1'b0, in} < OUT_W_EXT;
   // Ring wraps at the last real output, not at the top of the index range.
   assign idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;

   // Next-state and next-output decode: reset is handled in the register, then EN, then MODE.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out;
      idx_d   = idx;
      busy_d  = busy;
`ifdef DECODER_SEQ_STICKY_ERR_EN
      err_d   = err;
`else
      err_d   = 1'b0;
`endif
      if (!en) begin
         // Disable blanks the outputs and aborts any pulse; the index is kept.
         out_d   = '0;
         busy_d  = 1'b0;
         cnt_d   = '0;
         state_d = IDLE;
`ifdef DECODER_SEQ_STICKY_ERR_EN
         if (mode_s == MODE_HOLD) err_d = 1'b0;
`endif
      end else begin
         // Leaving PULSE mode aborts the pulse; the new mode acts this same cycle.
         if (mode_s != MODE_PULSE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
         case (mode_s)
            MODE_DIRECT: begin
               if (in_ok) begin
                  out_d = onehot(in);
                  idx_d = in;
               end else begin
                  out_d = '0;
                  err_d = 1'b1;
               end
            end
            MODE_HOLD: begin
               out_d = out;
            end
            MODE_STEP: begin
               if (step) begin
                  idx_d = idx_inc;
                  out_d = onehot(idx_inc);
               end else begin
                  out_d = onehot(idx);
               end
            end
            MODE_PULSE: begin
               if (state_q == IDLE) begin
                  if (in_ok) begin
                     out_d  = onehot(in);
                     idx_d  = in;
                     busy_d = 1'b0;
                     // A single-cycle pulse never needs the ACTIVE state.
                     if (PULSE_LEN > 1) begin
                        busy_d  = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = ACTIVE;
                     end
                  end else begin
                     out_d = '0;
                     err_d = 1'b1;
                  end
               end else if (cnt_q == 8'd0) begin
                  out_d   = '0;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out     <= '0;
         idx     <= '0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out     <= out_d;
         idx     <= idx_d;
         busy    <= busy_d;
         err     <= err_d;
      end
   end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: drives two decoder_seq instances (OUT_W=6/PULSE_LEN=3 and
// OUT_W=8/PULSE_LEN=1) from shared inputs and compares every output each cycle
// against a behavioural model, through directed steps and a random phase.
module tb_decoder_seq;

   logic       clk = 1'b0;
   logic       resetn, en, step;
   logic [1:0] mode;
   logic [2:0] in;

   logic [5:0] out_a;
   logic [2:0] idx_a;
   logic       busy_a, err_a;
   logic [7:0] out_b;
   logic [2:0] idx_b;
   logic       busy_b, err_b;

   int checks   = 0;
   int failures = 0;

   // Model state: age counts cycles since a pulse was accepted (0 = no pulse).
   typedef struct packed {
      int out;
      int idx;
      int busy;
      int err;
      int age;
   } mstate_t;

   mstate_t ma, mb;

   always #5 clk = ~clk;

   decoder_seq #(.SEL_W(3), .OUT_W(6), .PULSE_LEN(3)) dut_a (
      .clk(clk), .resetn(resetn), .in(in), .en(en), .mode(mode), .step(step),
      .out(out_a), .idx(idx_a), .busy(busy_a), .err(err_a)
   );

   decoder_seq #(.SEL_W(3), .OUT_W(8), .PULSE_LEN(1)) dut_b (
      .clk(clk), .resetn(resetn), .in(in), .en(en), .mode(mode), .step(step),
      .out(out_b), .idx(idx_b), .busy(busy_b), .err(err_b)
   );

   function automatic mstate_t mstep(mstate_t s, bit rn, bit e, logic [1:0] m,
                                     logic [2:0] i, bit st, int ow, int pl);
      mstate_t r;
      int      iv;
      int      mv;
      r  = s;
      iv = int'(i);
      mv = int'(m);
      if (!rn) begin
         r = '0;
         return r;
      end
`ifndef DECODER_SEQ_STICKY_ERR_EN
      r.err = 0;
`endif
      if (!e) begin
         r.out  = 0;
         r.age  = 0;
         r.busy = 0;
`ifdef DECODER_SEQ_STICKY_ERR_EN
         if (mv == 1) r.err = 0;
`endif
         return r;
      end
      if (mv != 3) r.age = 0;
      case (mv)
         0: begin
            if (iv < ow) begin
               r.out = 1 << iv;
               r.idx = iv;
            end else begin
               r.out = 0;
               r.err = 1;
            end
         end
         1: ;
         2: begin
            if (st) r.idx = (r.idx + 1) % ow;
            r.out = 1 << r.idx;
         end
         default: begin
            if (s.age == 0) begin
               if (iv < ow) begin
                  r.out = 1 << iv;
                  r.idx = iv;
                  r.age = (pl > 1) ? 1 : 0;
               end else begin
                  r.out = 0;
                  r.err = 1;
               end
            end else if (s.age == pl) begin
               r.out = 0;
               r.age = 0;
            end else begin
               r.age = s.age + 1;
            end
         end
      endcase
      r.busy = (r.age > 0) ? 1 : 0;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one set of inputs across one rising edge, advance the models, compare.
   task automatic cycle(input bit rn, input bit e, input logic [1:0] m,
                        input logic [2:0] i, input bit st);
      resetn = rn;
      en     = e;
      mode   = m;
      in     = i;
      step   = st;
      @(posedge clk);
      ma = mstep(ma, rn, e, m, i, st, 6, 3);
      mb = mstep(mb, rn, e, m, i, st, 8, 1);
      #1;
      check("out_a",  32'(out_a),  ma.out);
      check("idx_a",  32'(idx_a),  ma.idx);
      check("busy_a", 32'(busy_a), ma.busy);
      check("err_a",  32'(err_a),  ma.err);
      check("out_b",  32'(out_b),  mb.out);
      check("idx_b",  32'(idx_b),  mb.idx);
      check("busy_b", 32'(busy_b), mb.busy);
      check("err_b",  32'(err_b),  mb.err);
   endtask

   initial begin
      logic [1:0] cur_mode;
      ma = '0;
      mb = '0;

      // Reset for two cycles, then all outputs must be zero.
      cycle(1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
      cycle(1'b0, 1'b1, 2'b00, 3'd5, 1'b0);
      check("reset_out_a", 32'(out_a), 32'd0);
      check("reset_idx_a", 32'(idx_a), 32'd0);

      // DIRECT decode of 5, then EN=0 blanks OUT and keeps IDX.
      cycle(1'b1, 1'b1, 2'b00, 3'd5, 1'b0);
      check("direct5_out_a", 32'(out_a), 32'h20);
      check("direct5_idx_a", 32'(idx_a), 32'd5);
      cycle(1'b1, 1'b0, 2'b00, 3'd5, 1'b0);
      check("en0_out_a", 32'(out_a), 32'd0);
      check("en0_idx_a", 32'(idx_a), 32'd5);

      // Out-of-range select on the 6-output instance (IN=7, IN=6), then recover.
      cycle(1'b1, 1'b1, 2'b00, 3'd7, 1'b0);
      cycle(1'b1, 1'b1, 2'b00, 3'd6, 1'b0);
      cycle(1'b1, 1'b1, 2'b00, 3'd3, 1'b0);
      cycle(1'b1, 1'b0, 2'b01, 3'd3, 1'b0);
      cycle(1'b1, 1'b1, 2'b00, 3'd3, 1'b0);

      // STEP ring walk from index 4: wraps at the last real output.
      cycle(1'b1, 1'b1, 2'b00, 3'd4, 1'b0);
      cycle(1'b1, 1'b1, 2'b10, 3'd0, 1'b1);
      cycle(1'b1, 1'b1, 2'b10, 3'd7, 1'b1);
      check("step_wrap_idx_a", 32'(idx_a), 32'd0);
      cycle(1'b1, 1'b1, 2'b10, 3'd2, 1'b1);
      cycle(1'b1, 1'b0, 2'b10, 3'd2, 1'b0);
      cycle(1'b1, 1'b1, 2'b10, 3'd2, 1'b0);
      check("step_reassert_out_a", 32'(out_a), 32'h02);

      // PULSE of IN=2 for three cycles; IN=4 ignored while busy; gap then IN=4.
      cycle(1'b1, 1'b0, 2'b11, 3'd0, 1'b0);
      cycle(1'b1, 1'b1, 2'b11, 3'd2, 1'b0);
      check("pulse_start_out_a", 32'(out_a), 32'h04);
      cycle(1'b1, 1'b1, 2'b11, 3'd4, 1'b0);
      cycle(1'b1, 1'b1, 2'b11, 3'd4, 1'b0);
      check("pulse_last_busy_a", 32'(busy_a), 32'd1);
      cycle(1'b1, 1'b1, 2'b11, 3'd4, 1'b0);
      check("pulse_gap_out_a", 32'(out_a), 32'd0);
      cycle(1'b1, 1'b1, 2'b11, 3'd4, 1'b0);
      check("pulse_next_out_a", 32'(out_a), 32'h10);

      // Abort mid-pulse with EN=0, then with reset.
      cycle(1'b1, 1'b1, 2'b11, 3'd4, 1'b0);
      cycle(1'b1, 1'b0, 2'b11, 3'd4, 1'b0);
      cycle(1'b1, 1'b1, 2'b11, 3'd1, 1'b0);
      cycle(1'b1, 1'b1, 2'b11, 3'd1, 1'b0);
      cycle(1'b0, 1'b1, 2'b11, 3'd1, 1'b0);

      // Mode change mid-pulse takes effect the same cycle.
      cycle(1'b1, 1'b1, 2'b11, 3'd5, 1'b0);
      cycle(1'b1, 1'b1, 2'b00, 3'd1, 1'b0);

      // HOLD keeps OUT and IDX while IN wanders.
      cycle(1'b1, 1'b1, 2'b00, 3'd3, 1'b0);
      for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 2'b01, 3'($urandom_range(0, 7)), 1'b0);
      check("hold_out_a", 32'(out_a), 32'h08);
      check("hold_idx_a", 32'(idx_a), 32'd3);

      // Random phase: modes persist for a few cycles so pulses can complete.
      cur_mode = 2'b00;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) cur_mode = 2'($urandom_range(0, 3));
         cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0), cur_mode,
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Registered, parametrised N-to-M one-hot decoder for the simple processor unit's register-enable and bus-select fabric.
- Generalised successor of the 3-to-8 enable decoder.
- Adds four modes: direct decode, hold, step (one-hot ring walk for scan/sequenced register loads) and timed pulse (one-hot strobe held for PULSE_LEN cycles with busy handshake).
- Sits between the control FSM and the register-file/bus-mux enables.

Parameters:
- SEL_W, 3, width of select input IN and index output IDX.
- OUT_W, 8, number of one-hot outputs; legal range 2..2**SEL_W.
- PULSE_LEN, 1, cycles OUT stays asserted in PULSE mode; legal range 1..255.

Ports:
- CLK  input  1  rising-edge clock; single clock domain.
- RESETN  input  1  synchronous, active-low reset, sampled on rising CLK.
- IN  input  SEL_W  select index.
- EN  input  1  enable/request; EN=0 forces OUT to zero next cycle in every mode.
- MODE  input  2  00 DIRECT, 01 HOLD, 10 STEP, 11 PULSE.
- STEP  input  1  advance strobe, used in STEP mode only.
- OUT  output  OUT_W  registered one-hot; bit k set selects destination k.
- IDX  output  SEL_W  registered index of the current or last selected output.
- BUSY  output  1  high while a PULSE is in progress.
- ERR  output  1  high for one cycle after an out-of-range IN (IN >= OUT_W) was accepted.

Behaviour:
- Reset (RESETN=0 at a CLK edge): OUT=0, IDX=0, BUSY=0, ERR=0, pulse counter=0. Reset overrides everything, including a pulse in progress.
- Latency: all outputs are registered. An input sampled at edge t is visible after edge t.
- Priority, highest first: reset, then EN=0, then MODE action.
- EN=0:
  - OUT<=0, ERR<=0, IDX holds.
  - An active pulse is aborted: BUSY<=0, counter cleared.
- DIRECT (00), EN=1:
  - IN<OUT_W: OUT<=onehot(IN), IDX<=IN, ERR<=0.
  - IN>=OUT_W: OUT<=0, IDX holds, ERR<=1.
  - Tracks IN every cycle.
- HOLD (01), EN=1: OUT and IDX keep their values; ERR<=0.
- STEP (10), EN=1:
  - STEP=1: IDX<=(IDX==OUT_W-1)?0:IDX+1, OUT<=onehot(next IDX).
  - STEP=0: OUT<=onehot(IDX), which re-asserts the held index even if OUT was zero.
  - IN is ignored. Wrap-around at OUT_W-1, not at 2**SEL_W-1.
- PULSE (11), EN=1, state machine IDLE/ACTIVE:
  - IDLE and IN<OUT_W: OUT<=onehot(IN), IDX<=IN, BUSY<=1, counter<=PULSE_LEN-1, go to ACTIVE. If PULSE_LEN=1, BUSY stays 0 and the next cycle returns OUT to 0 unless a new request arrives.
  - IDLE and IN>=OUT_W: ERR<=1, OUT<=0, stay IDLE.
  - ACTIVE: IN is ignored (request not accepted while BUSY=1). Counter decrements each cycle. When counter==0: OUT<=0, BUSY<=0, go to IDLE.
  - A back-to-back request in the cycle BUSY falls is accepted on the next cycle, leaving a minimum one-cycle OUT=0 gap.
- MODE change mid-pulse: the FSM aborts to IDLE, BUSY<=0, and the new mode takes effect in the same cycle.
- OUT is always one-hot or zero; never multi-hot.

Optional Feature:
- Macro DECODER_SEQ_STICKY_ERR_EN.
- Defined: ERR is sticky. It sets on any out-of-range accept and clears only on reset or on a cycle with EN=0 and MODE=01.
- Undefined: ERR is a one-cycle flag as described in Behaviour.

Test Plan:
- Reset then DIRECT: RESETN=0 for 2 cycles, then EN=1, MODE=00, IN=5 -> OUT=8'h20 and IDX=5 one cycle after the edge; EN=0 -> OUT=0 next cycle, IDX stays 5.
- Range check with OUT_W=6, SEL_W=3: IN=7 in DIRECT -> OUT=0, ERR=1 for one cycle, IDX unchanged. With DECODER_SEQ_STICKY_ERR_EN, ERR stays 1 until EN=0 with MODE=01.
- STEP wrap with OUT_W=8: IDX=6, MODE=10, three STEP pulses -> OUT sequence 8'h80, 8'h01, 8'h02 and IDX sequence 7, 0, 1.
- PULSE with PULSE_LEN=3: IN=2 -> OUT=8'h04 for exactly 3 cycles and BUSY=1 for those 3. IN=4 during BUSY is ignored. A request after BUSY falls gives OUT=8'h10 following a one-cycle zero gap.
- Abort: mid-pulse (cycle 2 of 3), first drive EN=0 -> next cycle OUT=0, BUSY=0. Repeat with a synchronous RESETN=0 -> all outputs zero on the next edge.
- HOLD: after DIRECT IN=3, switch to MODE=01 and toggle IN randomly for 10 cycles -> OUT stays 8'h08 and IDX stays 3.
